// File: rtl/ifu_mem_req_arbiter.sv
// Arbitrates the single memory port between IFU demand misses and prefetches.
// One transaction in flight; a same-line demand can ride on an outstanding prefetch.
module ifu_mem_req_arbiter #(
    parameter int ADDR_WIDTH    = 32,
    parameter int LINE_WIDTH    = 128,
    parameter int OFFSET_BITS   = 4,
    parameter int MAX_PF_STARVE = 8
) (
    input  logic                  Clock,
    input  logic                  Rst,
    input  logic                  dmd_req_valid_in,
    input  logic [ADDR_WIDTH-1:0] dmd_req_addr_in,
    output logic                  dmd_req_ready_out,
    output logic                  dmd_rsp_valid_out,
    output logic [LINE_WIDTH-1:0] dmd_rsp_data_out,
    input  logic                  pf_req_valid_in,
    input  logic [ADDR_WIDTH-1:0] pf_req_addr_in,
    output logic                  pf_req_ready_out,
    output logic                  pf_rsp_valid_out,
    output logic [ADDR_WIDTH-1:0] pf_rsp_addr_out,
    output logic [LINE_WIDTH-1:0] pf_rsp_data_out,
    output logic                  mem_req_valid_out,
    output logic [ADDR_WIDTH-1:0] mem_req_addr_out,
    input  logic                  mem_req_ready_in,
    input  logic                  mem_rsp_valid_in,
    input  logic [LINE_WIDTH-1:0] mem_rsp_data_in,
    output logic                  busy_out
);
    localparam int CNT_W = (MAX_PF_STARVE > 0) ? $clog2(MAX_PF_STARVE + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PF_STARVE);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t                  state_q, state_d;
    logic                    owner_q, owner_d;      // 1 = prefetch owns the transaction
    logic                    merge_q, merge_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]        starve_q, starve_d;
    logic                    dmd_rsp_v_q, dmd_rsp_v_d;
    logic                    pf_rsp_v_q, pf_rsp_v_d;
    logic [LINE_WIDTH-1:0]   dmd_data_q, dmd_data_d;
    logic [LINE_WIDTH-1:0]   pf_data_q, pf_data_d;
    logic [ADDR_WIDTH-1:0]   pf_addr_q, pf_addr_d;

    logic                    dmd_ready, pf_ready, merge_hit, force_pf, same_line;
    logic [CNT_W-1:0]        starve_inc;
    logic [ADDR_WIDTH-1:0]   dmd_line, pf_line;
    logic                    unused_offsets;

    assign dmd_line       = {dmd_req_addr_in[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    assign pf_line        = {pf_req_addr_in[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    assign unused_offsets = ^{dmd_req_addr_in[OFFSET_BITS-1:0], pf_req_addr_in[OFFSET_BITS-1:0]};
    assign same_line      = (dmd_line == pf_line);
    assign force_pf       = (MAX_PF_STARVE != 0) && (starve_q >= CNT_MAX);
    assign starve_inc     = (starve_q < CNT_MAX) ? starve_q + 1'b1 : starve_q;
    assign merge_hit      = (state_q != S_IDLE) && owner_q && !merge_q &&
                            dmd_req_valid_in && (dmd_line == addr_q);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        merge_d     = merge_q;
        addr_d      = addr_q;
        starve_d    = starve_q;
        dmd_ready   = 1'b0;
        pf_ready    = 1'b0;
        dmd_rsp_v_d = 1'b0;
        pf_rsp_v_d  = 1'b0;
        dmd_data_d  = dmd_data_q;
        pf_data_d   = pf_data_q;
        pf_addr_d   = pf_addr_q;

        if (state_q == S_IDLE) begin
            if (dmd_req_valid_in && pf_req_valid_in && same_line) begin
                // Same line requested by both: demand issues, prefetch is swallowed.
                dmd_ready = 1'b1;
                pf_ready  = 1'b1;
                owner_d   = 1'b0;
                addr_d    = dmd_line;
                state_d   = S_REQ;
            end else if (dmd_req_valid_in && !(pf_req_valid_in && force_pf)) begin
                dmd_ready = 1'b1;
                owner_d   = 1'b0;
                addr_d    = dmd_line;
                state_d   = S_REQ;
            end else if (pf_req_valid_in) begin
                pf_ready  = 1'b1;
                owner_d   = 1'b1;
                addr_d    = pf_line;
                state_d   = S_REQ;
            end
            starve_d = (!pf_req_valid_in || pf_ready) ? '0 : starve_inc;
        end else begin
            starve_d = pf_req_valid_in ? starve_inc : '0;
            if (merge_hit) begin
                dmd_ready = 1'b1;
                merge_d   = 1'b1;
            end
            if (state_q == S_REQ && mem_req_ready_in) begin
                state_d = S_WAIT;
            end
            if (state_q == S_WAIT && mem_rsp_valid_in) begin
                state_d     = S_IDLE;
                merge_d     = 1'b0;
                dmd_rsp_v_d = !owner_q || merge_q || merge_hit;
                pf_rsp_v_d  = owner_q;
                if (!owner_q || merge_q || merge_hit) begin
                    dmd_data_d = mem_rsp_data_in;
                end
                if (owner_q) begin
                    pf_data_d = mem_rsp_data_in;
                    pf_addr_d = addr_q;
                end
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Rst) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            merge_q     <= 1'b0;
            addr_q      <= '0;
            starve_q    <= '0;
            dmd_rsp_v_q <= 1'b0;
            pf_rsp_v_q  <= 1'b0;
            dmd_data_q  <= '0;
            pf_data_q   <= '0;
            pf_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            merge_q     <= merge_d;
            addr_q      <= addr_d;
            starve_q    <= starve_d;
            dmd_rsp_v_q <= dmd_rsp_v_d;
            pf_rsp_v_q  <= pf_rsp_v_d;
            dmd_data_q  <= dmd_data_d;
            pf_data_q   <= pf_data_d;
            pf_addr_q   <= pf_addr_d;
        end
    end

    assign dmd_req_ready_out = dmd_ready && !Rst;
    assign pf_req_ready_out  = pf_ready && !Rst;
    assign dmd_rsp_valid_out = dmd_rsp_v_q;
    assign dmd_rsp_data_out  = dmd_data_q;
    assign pf_rsp_valid_out  = pf_rsp_v_q;
    assign pf_rsp_addr_out   = pf_addr_q;
    assign pf_rsp_data_out   = pf_data_q;
    assign mem_req_valid_out = (state_q == S_REQ);
    assign mem_req_addr_out  = addr_q;
    assign busy_out          = (state_q != S_IDLE);

endmodule

// File: tb/tb_ifu_mem_req_arbiter.sv
// Directed bench for ifu_mem_req_arbiter: demand, ordering, starvation,
// merge, same-line drop and mid-transaction reset, all with hand-computed expectations.
module tb_ifu_mem_req_arbiter;
    logic         clk = 1'b0;
    logic         rst;
    logic         dmd_v, pf_v, mem_rdy, mem_rsp_v;
    logic [31:0]  dmd_a, pf_a;
    logic [127:0] mem_data;
    logic         dmd_rdy, dmd_rsp_v, pf_rdy, pf_rsp_v, mem_req_v, busy;
    logic [127:0] dmd_rsp_d, pf_rsp_d;
    logic [31:0]  pf_rsp_a, mem_req_a;

    int n_total = 0;
    int n_pass  = 0;

    localparam logic [127:0] D1 = {4{32'hA1A1_0001}};
    localparam logic [127:0] D2 = {4{32'hB2B2_0002}};
    localparam logic [127:0] D3 = {4{32'hC3C3_0003}};
    localparam logic [127:0] D4 = {4{32'hD4D4_0004}};
    localparam logic [127:0] D5 = {4{32'hE5E5_0005}};

    always #5 clk = ~clk;

    ifu_mem_req_arbiter dut (
        .Clock             (clk),
        .Rst               (rst),
        .dmd_req_valid_in  (dmd_v),
        .dmd_req_addr_in   (dmd_a),
        .dmd_req_ready_out (dmd_rdy),
        .dmd_rsp_valid_out (dmd_rsp_v),
        .dmd_rsp_data_out  (dmd_rsp_d),
        .pf_req_valid_in   (pf_v),
        .pf_req_addr_in    (pf_a),
        .pf_req_ready_out  (pf_rdy),
        .pf_rsp_valid_out  (pf_rsp_v),
        .pf_rsp_addr_out   (pf_rsp_a),
        .pf_rsp_data_out   (pf_rsp_d),
        .mem_req_valid_out (mem_req_v),
        .mem_req_addr_out  (mem_req_a),
        .mem_req_ready_in  (mem_rdy),
        .mem_rsp_valid_in  (mem_rsp_v),
        .mem_rsp_data_in   (mem_data),
        .busy_out          (busy)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starvation scenario: expected readies per cycle, bit k = cycle k.
    logic [14:0] exp_dmd_rdy = 15'b001_0000_0100_1001;
    logic [14:0] exp_pf_rdy  = 15'b000_0010_0000_0000;

    initial begin
        rst = 1'b1; dmd_v = 1'b0; pf_v = 1'b0; mem_rdy = 1'b0; mem_rsp_v = 1'b0;
        dmd_a = '0; pf_a = '0; mem_data = '0;
        tick(); tick();
        dmd_v = 1'b1; pf_v = 1'b1; dmd_a = 32'h104; pf_a = 32'h900;
        #1;
        chk("rst_dmd_ready", dmd_rdy, 1'b0);
        chk("rst_pf_ready", pf_rdy, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_req_v", mem_req_v, 1'b0);
        chk("rst_mem_addr", mem_req_a, 32'h0);
        chk("rst_dmd_rsp_v", dmd_rsp_v, 1'b0);
        dmd_v = 1'b0; pf_v = 1'b0;
        tick();
        rst = 1'b0;
        $display("txn reset checked");

        // Demand only 0x104, memory ready at once, response 3 cycles after issue.
        dmd_v = 1'b1; dmd_a = 32'h104; mem_rdy = 1'b1;
        #1;
        chk("t1_dmd_ready", dmd_rdy, 1'b1);
        tick(); dmd_v = 1'b0;
        chk("t1_mem_req_v", mem_req_v, 1'b1);
        chk("t1_mem_addr", mem_req_a, 32'h100);
        chk("t1_busy", busy, 1'b1);
        tick();
        chk("t1_wait_req_v", mem_req_v, 1'b0);
        tick();
        mem_rsp_v = 1'b1; mem_data = D1;
        tick(); mem_rsp_v = 1'b0;
        chk("t1_dmd_rsp_v", dmd_rsp_v, 1'b1);
        chk("t1_dmd_rsp_d", dmd_rsp_d, D1);
        chk("t1_pf_rsp_v", pf_rsp_v, 1'b0);
        chk("t1_busy_after", busy, 1'b0);
        tick();
        chk("t1_pulse_end", dmd_rsp_v, 1'b0);
        $display("txn demand 0x104 done");

        // Demand 0x200 vs prefetch 0x300; memory stalls the request one cycle.
        dmd_v = 1'b1; dmd_a = 32'h200; pf_v = 1'b1; pf_a = 32'h300; mem_rdy = 1'b0;
        #1;
        chk("t2_dmd_ready", dmd_rdy, 1'b1);
        chk("t2_pf_ready", pf_rdy, 1'b0);
        tick(); dmd_v = 1'b0;
        chk("t2_mem_addr", mem_req_a, 32'h200);
        tick();
        chk("t2_hold_v", mem_req_v, 1'b1);
        chk("t2_hold_addr", mem_req_a, 32'h200);
        chk("t2_pf_blocked", pf_rdy, 1'b0);
        mem_rdy = 1'b1;
        tick();
        mem_rsp_v = 1'b1; mem_data = D2;
        tick(); mem_rsp_v = 1'b0;
        chk("t2_dmd_rsp_v", dmd_rsp_v, 1'b1);
        chk("t2_dmd_rsp_d", dmd_rsp_d, D2);
        #1;
        chk("t2_pf_ready_next", pf_rdy, 1'b1);
        tick(); pf_v = 1'b0;
        chk("t2_pf_mem_addr", mem_req_a, 32'h300);
        tick();
        mem_rsp_v = 1'b1; mem_data = D3;
        tick(); mem_rsp_v = 1'b0;
        chk("t2_pf_rsp_v", pf_rsp_v, 1'b1);
        chk("t2_pf_rsp_a", pf_rsp_a, 32'h300);
        chk("t2_pf_rsp_d", pf_rsp_d, D3);
        chk("t2_no_dmd_rsp", dmd_rsp_v, 1'b0);
        $display("txn demand 0x200 then prefetch 0x300 done");

        // Continuous demand with prefetch 0x400 held until it is force-granted.
        dmd_v = 1'b1; dmd_a = 32'h1000; pf_a = 32'h400; mem_rdy = 1'b1;
        mem_rsp_v = 1'b1; mem_data = D4;
        for (int k = 0; k < 15; k++) begin
            pf_v = (k <= 9);
            #1;
            chk($sformatf("t3_dmd_ready_c%0d", k), dmd_rdy, exp_dmd_rdy[k]);
            chk($sformatf("t3_pf_ready_c%0d", k), pf_rdy, exp_pf_rdy[k]);
            if (k == 10) chk("t3_pf_mem_addr", mem_req_a, 32'h400);
            if (k == 12) chk("t3_pf_rsp_v", pf_rsp_v, 1'b1);
            tick();
        end
        dmd_v = 1'b0; pf_v = 1'b0; mem_rsp_v = 1'b0;
        chk("t3_busy_after", busy, 1'b0);
        $display("txn starvation force-grant done");

        // Prefetch 0x500 outstanding, demand 0x508 merges during WAIT.
        pf_v = 1'b1; pf_a = 32'h500;
        #1;
        chk("t4_pf_ready", pf_rdy, 1'b1);
        tick(); pf_v = 1'b0;
        tick();
        dmd_v = 1'b1; dmd_a = 32'h508;
        #1;
        chk("t4_merge_ready", dmd_rdy, 1'b1);
        tick(); dmd_v = 1'b0;
        chk("t4_no_2nd_req", mem_req_v, 1'b0);
        chk("t4_busy", busy, 1'b1);
        mem_rsp_v = 1'b1; mem_data = D4;
        tick(); mem_rsp_v = 1'b0;
        chk("t4_dmd_rsp_v", dmd_rsp_v, 1'b1);
        chk("t4_pf_rsp_v", pf_rsp_v, 1'b1);
        chk("t4_dmd_rsp_d", dmd_rsp_d, D4);
        chk("t4_pf_rsp_d", pf_rsp_d, D4);
        chk("t4_pf_rsp_a", pf_rsp_a, 32'h500);
        tick();
        chk("t4_idle_no_req", mem_req_v, 1'b0);
        $display("txn merge 0x508 onto prefetch 0x500 done");

        // Demand and prefetch to line 0x600 together: prefetch dropped.
        dmd_v = 1'b1; dmd_a = 32'h604; pf_v = 1'b1; pf_a = 32'h600;
        #1;
        chk("t5_dmd_ready", dmd_rdy, 1'b1);
        chk("t5_pf_ready", pf_rdy, 1'b1);
        tick(); dmd_v = 1'b0; pf_v = 1'b0;
        chk("t5_mem_addr", mem_req_a, 32'h600);
        tick();
        chk("t5_single_req", mem_req_v, 1'b0);
        mem_rsp_v = 1'b1; mem_data = D5;
        tick(); mem_rsp_v = 1'b0;
        chk("t5_dmd_rsp_v", dmd_rsp_v, 1'b1);
        chk("t5_no_pf_rsp", pf_rsp_v, 1'b0);
        tick();
        chk("t5_no_2nd_req", mem_req_v, 1'b0);
        $display("txn same-line drop 0x600 done");

        // Reset while waiting; the late response must be ignored.
        dmd_v = 1'b1; dmd_a = 32'h700;
        tick(); dmd_v = 1'b0;
        tick();
        chk("t6_in_wait", busy, 1'b1);
        rst = 1'b1;
        tick();
        chk("t6_rst_busy", busy, 1'b0);
        rst = 1'b0; mem_rsp_v = 1'b1; mem_data = D1;
        tick(); mem_rsp_v = 1'b0;
        chk("t6_no_dmd_rsp", dmd_rsp_v, 1'b0);
        chk("t6_no_pf_rsp", pf_rsp_v, 1'b0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_mem_req_v", mem_req_v, 1'b0);
        chk("t6_mem_addr", mem_req_a, 32'h0);
        chk("t6_dmd_rsp_d", dmd_rsp_d, 128'h0);
        chk("t6_pf_rsp_d", pf_rsp_d, 128'h0);
        chk("t6_pf_rsp_a", pf_rsp_a, 32'h0);
        $display("txn reset in WAIT done");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
